// File: rtl/mix_pkg.sv
// mix_pkg: MIX word/byte geometry, block sizes and OUT-unit state encoding
package mix_pkg;
   localparam int MIX_WORD_W     = 31;
   localparam int MIX_BYTE_W     = 6;
   localparam int MIX_ADDR_W     = 12;
   localparam int BYTES_PER_WORD = 5;
   localparam int PRINTER_BLOCK  = 24;
   localparam int PUNCH_BLOCK    = 16;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_READ = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_EMIT = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;
endpackage

// File: rtl/mix_word_unpack.sv
// mix_word_unpack: pick character idx of a MIX word, byte 1 (bits 29:24) first; sign never selected
module mix_word_unpack
   import mix_pkg::*;
(
   input  logic [MIX_WORD_W-1:0] word,
   input  logic [2:0]            idx,
   output logic [MIX_BYTE_W-1:0] ch
);
   always_comb
      ch = idx > 3'(BYTES_PER_WORD - 1) ? '0
         : MIX_BYTE_W'(word >> (MIX_BYTE_W * (3'(BYTES_PER_WORD - 1) - idx)));
endmodule

// File: rtl/mix_out_unit.sv
// mix_out_unit: MIX OUT block responder, reads BLOCK_WORDS words and streams their characters
module mix_out_unit
   import mix_pkg::*;
#(
   parameter int BLOCK_WORDS = PRINTER_BLOCK,
   parameter int ADDR_W      = MIX_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [MIX_WORD_W-1:0] mem_data,
   output logic [MIX_BYTE_W-1:0] char_data,
   output logic                  char_valid,
   input  logic                  char_ready
);
   localparam int CW = $clog2(BLOCK_WORDS + 1);
   logic [2:0]            state;
   logic [ADDR_W-1:0]     addr;
   logic [CW-1:0]         cnt;
   logic [2:0]            idx;
   logic [MIX_WORD_W-1:0] word;
   logic [MIX_BYTE_W-1:0] ch;
   logic                  last_byte, last_word;
   mix_word_unpack u_unpack (.word(word), .idx(idx), .ch(ch));
   assign last_byte  = idx == 3'(BYTES_PER_WORD - 1);
   assign last_word  = cnt == CW'(BLOCK_WORDS - 1);
   assign busy       = state != ST_IDLE;
   assign done       = state == ST_FIN;
   assign mem_rd     = state == ST_READ;
   assign char_valid = state == ST_EMIT;
   assign char_data  = char_valid ? ch : '0;
   // addr only advances toward another READ, so mem_addr keeps the last word read
   assign mem_addr   = addr;
   always_ff @(posedge clk)
      if (reset) begin
         state <= ST_IDLE;
         addr  <= '0;
         cnt   <= '0;
         idx   <= '0;
         word  <= '0;
      end else
         case (state)
            ST_IDLE:
               if (start) begin
                  addr  <= start_addr;
                  cnt   <= '0;
                  state <= ST_READ;
               end
            ST_READ: state <= ST_WAIT;
            ST_WAIT: begin
               word  <= mem_data;
               idx   <= '0;
               state <= ST_EMIT;
            end
            ST_EMIT:
               if (char_ready) begin
                  if (last_byte) begin
                     cnt <= cnt + 1'b1;
                     if (last_word) state <= ST_FIN;
                     else begin
                        addr  <= addr + 1'b1;
                        state <= ST_READ;
                     end
                  end else idx <= idx + 3'd1;
               end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: tb/tb_mix_out_unit.sv
// tb_mix_out_unit: scoreboard bench for mix_out_unit with a 2-word block and a synchronous RAM model
module tb_mix_out_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1, start = 1'b0, char_ready = 1'b0;
   logic [11:0] start_addr = '0;
   logic        busy, done, mem_rd, char_valid;
   logic [11:0] mem_addr;
   logic [30:0] mem_data;
   logic [5:0]  char_data;
   logic [30:0] mem [4096];
   logic [5:0]  exp_q[$];
   logic [11:0] addr_q[$];
   int          n_checks = 0, n_fail = 0;

   mix_out_unit #(.BLOCK_WORDS(2), .ADDR_W(12)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .char_data(char_data), .char_valid(char_valid),
      .char_ready(char_ready));

   always #5 clk = ~clk;
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   function automatic logic [30:0] pack(input logic s, input logic [5:0] a, b, c, d, e);
      return {s, a, b, c, d, e};
   endfunction

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1; start = 1'b1; start_addr = 12'd55;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, mem_rd, char_valid} !== 4'b0 || mem_addr !== 12'd0 || char_data !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b mem_rd=%b char_valid=%b mem_addr=%0d char_data=%0d, want all 0",
                  busy, done, mem_rd, char_valid, mem_addr, char_data);
      end
      reset = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || mem_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored: busy=%b mem_rd=%b, want 0 0", busy, mem_rd);
      end
   endtask

   task automatic test_block;
      int cyc = 0, done_cyc = 0;
      logic [5:0] e;
      mem[100] = pack(1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
      mem[101] = pack(1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10);
      for (int i = 1; i <= 10; i++) exp_q.push_back(6'(i));
      char_ready = 1'b1; start_addr = 12'd100; start = 1'b1;
      while (done_cyc == 0 && cyc < 200) begin
         @(negedge clk); cyc++; start = 1'b0;
         if (cyc == 1) begin
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL block_busy: got %b want 1", busy); end
         end
         if (char_valid && char_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL block_char: extra char %0d, none expected", char_data); end
            else begin
               e = exp_q.pop_front();
               if (char_data !== e) begin n_fail++; $display("FAIL block_char: got %0d want %0d", char_data, e); end
            end
         end
         if (done === 1'b1) done_cyc = cyc;
      end
      n_checks++;
      if (done_cyc != 15) begin n_fail++; $display("FAIL block_done_time: done at cycle %0d want 15", done_cyc); end
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL block_missing: %0d chars left want 0", exp_q.size()); end
      exp_q.delete();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL block_after: busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_backpressure;
      int cyc = 0;
      logic got_done = 1'b0, stalled = 1'b0;
      logic [5:0] held = '0, e;
      for (int i = 1; i <= 10; i++) exp_q.push_back(6'(i));
      start_addr = 12'd100; start = 1'b1;
      while (!got_done && cyc < 400) begin
         @(negedge clk); cyc++; start = 1'b0;
         if (stalled) begin
            n_checks++;
            if (char_valid !== 1'b1 || char_data !== held) begin
               n_fail++;
               $display("FAIL bp_stable: valid=%b data=%0d want 1 %0d", char_valid, char_data, held);
            end
         end
         char_ready = 1'($urandom_range(0, 1));
         stalled = char_valid && !char_ready;
         held = char_data;
         if (char_valid && char_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_char: extra char %0d, none expected", char_data); end
            else begin
               e = exp_q.pop_front();
               if (char_data !== e) begin n_fail++; $display("FAIL bp_char: got %0d want %0d", char_data, e); end
            end
         end
         if (done === 1'b1) got_done = 1'b1;
      end
      char_ready = 1'b1;
      n_checks++;
      if (!got_done || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_complete: done_seen=%b chars_left=%0d want 1 0", got_done, exp_q.size());
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_wrap;
      int cyc = 0;
      logic got_done = 1'b0;
      logic [5:0] e;
      logic [11:0] ea;
      mem[4095] = pack(1'b0, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15);
      mem[0]    = pack(1'b0, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20);
      for (int i = 11; i <= 20; i++) exp_q.push_back(6'(i));
      addr_q.push_back(12'd4095); addr_q.push_back(12'd0);
      char_ready = 1'b1; start_addr = 12'd4095; start = 1'b1;
      while (!got_done && cyc < 200) begin
         @(negedge clk); cyc++; start = 1'b0;
         if (mem_rd) begin
            n_checks++;
            if (addr_q.size() == 0) begin n_fail++; $display("FAIL wrap_addr: extra read at %0d", mem_addr); end
            else begin
               ea = addr_q.pop_front();
               if (mem_addr !== ea) begin n_fail++; $display("FAIL wrap_addr: got %0d want %0d", mem_addr, ea); end
            end
         end
         if (char_valid && char_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_char: extra char %0d, none expected", char_data); end
            else begin
               e = exp_q.pop_front();
               if (char_data !== e) begin n_fail++; $display("FAIL wrap_char: got %0d want %0d", char_data, e); end
            end
         end
         if (done === 1'b1) got_done = 1'b1;
      end
      n_checks++;
      if (!got_done || exp_q.size() != 0 || addr_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_complete: done_seen=%b chars_left=%0d reads_left=%0d want 1 0 0",
                  got_done, exp_q.size(), addr_q.size());
      end
      exp_q.delete(); addr_q.delete();
      @(negedge clk);
   endtask

   task automatic test_sign;
      int cyc = 0;
      logic got_done = 1'b0;
      logic [5:0] e;
      mem[300] = pack(1'b1, 6'd63, 6'd0, 6'd63, 6'd0, 6'd63);
      mem[301] = pack(1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
      exp_q = '{6'd63, 6'd0, 6'd63, 6'd0, 6'd63, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
      char_ready = 1'b1; start_addr = 12'd300; start = 1'b1;
      while (!got_done && cyc < 200) begin
         @(negedge clk); cyc++; start = 1'b0;
         if (char_valid && char_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL sign_char: extra char %0d, none expected", char_data); end
            else begin
               e = exp_q.pop_front();
               if (char_data !== e) begin n_fail++; $display("FAIL sign_char: got %0d want %0d", char_data, e); end
            end
         end
         if (done === 1'b1) got_done = 1'b1;
      end
      n_checks++;
      if (!got_done || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sign_complete: done_seen=%b chars_left=%0d want 1 0", got_done, exp_q.size());
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_start_while_busy;
      int cyc = 0, done_cyc = 0;
      logic [5:0] e;
      mem[200] = pack(1'b0, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44);
      mem[201] = pack(1'b0, 6'd45, 6'd46, 6'd47, 6'd48, 6'd49);
      for (int i = 1; i <= 10; i++) exp_q.push_back(6'(i));
      char_ready = 1'b1; start_addr = 12'd100; start = 1'b1;
      while (done_cyc == 0 && cyc < 200) begin
         @(negedge clk); cyc++; start = 1'b0;
         if (cyc == 3) begin start = 1'b1; start_addr = 12'd200; end
         if (char_valid && char_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL busy_start_char: extra char %0d, none expected", char_data); end
            else begin
               e = exp_q.pop_front();
               if (char_data !== e) begin n_fail++; $display("FAIL busy_start_char: got %0d want %0d", char_data, e); end
            end
         end
         if (done === 1'b1) done_cyc = cyc;
      end
      n_checks++;
      if (done_cyc != 15 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL busy_start_done: done at %0d chars_left=%0d want 15 0", done_cyc, exp_q.size());
      end
      exp_q.delete();
      // a start presented during the done cycle must be dropped
      start = 1'b1; start_addr = 12'd200;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || mem_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL start_on_done: busy=%b mem_rd=%b want 0 0", busy, mem_rd);
      end
   endtask

   task automatic test_reset_mid;
      int cyc = 0, nacc = 0;
      logic hit = 1'b0, bad = 1'b0;
      logic [5:0] e;
      for (int i = 1; i <= 10; i++) exp_q.push_back(6'(i));
      char_ready = 1'b1; start_addr = 12'd100; start = 1'b1;
      while (!hit && cyc < 100) begin
         @(negedge clk); cyc++; start = 1'b0;
         if (char_valid && nacc == 2) begin reset = 1'b1; hit = 1'b1; end
         else if (char_valid && char_ready) begin
            e = exp_q.pop_front(); nacc++;
            n_checks++;
            if (char_data !== e) begin n_fail++; $display("FAIL mid_char: got %0d want %0d", char_data, e); end
         end
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL mid_third_char: third char never presented within budget"); end
      @(negedge clk);
      n_checks++;
      if ({busy, done, mem_rd, char_valid} !== 4'b0 || char_data !== 6'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: busy=%b done=%b mem_rd=%b valid=%b data=%0d want all 0",
                  busy, done, mem_rd, char_valid, char_data);
      end
      reset = 1'b0;
      exp_q.delete();
      repeat (20) begin
         @(negedge clk);
         if (done !== 1'b0 || char_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL mid_no_done: activity seen after abort, want idle"); end
   endtask

   initial begin
      test_reset();
      test_block();
      test_backpressure();
      test_wrap();
      test_sign();
      test_start_while_busy();
      test_reset_mid();
      test_block();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
